// File: rtl/tcdm_block_reader_pkg.sv
// Shared FSM encoding and fixed TCDM request attributes for the block reader.
package tcdm_block_reader_pkg;

  typedef logic [1:0] rdr_state_t;

  localparam rdr_state_t IDLE  = 2'd0;
  localparam rdr_state_t RUN   = 2'd1;
  localparam rdr_state_t DRAIN = 2'd2;

  localparam logic       TCDM_WEN_READ = 1'b1;
  localparam logic [3:0] TCDM_BE_WORD  = 4'hF;

  // The interconnect is word addressed; the byte offset is dropped, never rounded.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/tcdm_rdr_fifo.sv
// Response buffer: DEPTH x 32 circular FIFO, head visible combinationally, zero-latency pop.
// Push on full is accepted only together with a pop; pop on empty is ignored.
module tcdm_rdr_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     i_push,
  input  logic [31:0]              i_push_dat,
  input  logic                     i_pop,
  output logic [31:0]              o_head_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rptr];

  // A full FIFO can still take a word in the cycle its head leaves.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_dat;
  end

endmodule

// File: rtl/tcdm_block_reader.sv
// Streams len_i words from TCDM at base_addr_i to a valid/ready consumer, issuing reads only when buffer space is reserved.
// Optional XOR checksum of delivered words is enabled by defining TCDM_RDR_CHECKSUM_EN.
module tcdm_block_reader
  import tcdm_block_reader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tcdm_req_o,
  output logic [31:0]          tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [3:0]           tcdm_be_o,
  output logic [31:0]          tcdm_wdata_o,
  input  logic                 tcdm_gnt_i,
  input  logic                 tcdm_r_valid_i,
  input  logic [31:0]          tcdm_r_rdata_i,
  output logic [31:0]          data_o,
  output logic                 valid_o,
  input  logic                 ready_i
`ifdef TCDM_RDR_CHECKSUM_EN
  ,
  output logic [31:0]          checksum_o
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  rdr_state_t           r_state;
  logic [31:0]          r_addr;
  logic [LEN_WIDTH-1:0] r_req_left;
  logic [LEN_WIDTH-1:0] r_remain;
  logic [CW-1:0]        r_outstanding;
  logic                 r_done_zero;

  logic          w_start;
  logic          w_gnt;
  logic          w_last_gnt;
  logic          w_push;
  logic          w_pop;
  logic          w_last_pop;
  logic          w_room;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  logic [CW:0]   w_inflight;

  assign w_start = (r_state == IDLE) && start_i;

  // Buffered plus in-flight words never exceed the buffer, so a response always has a slot.
  // Without a grant this sum cannot grow, which keeps an ungranted request asserted.
  assign w_inflight = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
  assign w_room     = !w_fifo_full && (w_inflight < (CW + 1)'(FIFO_DEPTH));

  assign tcdm_req_o   = (r_state == RUN) && w_room;
  assign tcdm_add_o   = r_addr;
  assign tcdm_wen_o   = TCDM_WEN_READ;
  assign tcdm_be_o    = TCDM_BE_WORD;
  assign tcdm_wdata_o = '0;

  assign w_gnt      = tcdm_req_o && tcdm_gnt_i;
  assign w_last_gnt = w_gnt && (r_req_left == LEN_WIDTH'(1));
  // Stray responses left over from an aborted transfer are dropped.
  assign w_push     = tcdm_r_valid_i && (r_state != IDLE) && (r_outstanding != '0);

  assign valid_o    = !w_fifo_empty;
  assign w_pop      = valid_o && ready_i;
  assign w_last_pop = w_pop && (r_state != IDLE) && (r_remain == LEN_WIDTH'(1));

  assign busy_o = (r_state != IDLE);
  assign done_o = r_done_zero || w_last_pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_req_left    <= '0;
      r_remain      <= '0;
      r_outstanding <= '0;
      r_done_zero   <= 1'b0;
    end else begin
      r_done_zero   <= w_start && (len_i == '0);
      r_outstanding <= r_outstanding + CW'(w_gnt) - CW'(w_push);
      case (r_state)
        IDLE: begin
          if (w_start && (len_i != '0)) begin
            r_state    <= RUN;
            r_addr     <= word_align(base_addr_i);
            r_req_left <= len_i;
            r_remain   <= len_i;
          end
        end
        RUN, DRAIN: begin
          if (w_gnt) begin
            r_addr     <= r_addr + 32'd4;
            r_req_left <= r_req_left - LEN_WIDTH'(1);
          end
          if (w_pop) r_remain <= r_remain - LEN_WIDTH'(1);
          if (w_last_pop)      r_state <= IDLE;
          else if (w_last_gnt) r_state <= DRAIN;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  tcdm_rdr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_push     (w_push),
    .i_push_dat (tcdm_r_rdata_i),
    .i_pop      (w_pop),
    .o_head_dat (data_o),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_count    (w_fifo_count)
  );

`ifdef TCDM_RDR_CHECKSUM_EN
  logic [31:0] r_csum;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     r_csum <= '0;
    else if (w_start) r_csum <= '0;
    else if (w_pop)   r_csum <= r_csum ^ data_o;
  end

  // Fold in the word being accepted so the value is already final on the done cycle.
  assign checksum_o = w_pop ? (r_csum ^ data_o) : r_csum;
`endif

endmodule

// File: tb/tb_tcdm_block_reader.sv
// Randomized bench: behavioural TCDM memory with in-order random-latency responses and a word-stream scoreboard.
module tb_tcdm_block_reader;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned LEN_WIDTH  = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 start_i;
  logic [31:0]          base_addr_i;
  logic [LEN_WIDTH-1:0] len_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 tcdm_req_o;
  logic [31:0]          tcdm_add_o;
  logic                 tcdm_wen_o;
  logic [3:0]           tcdm_be_o;
  logic [31:0]          tcdm_wdata_o;
  logic                 tcdm_gnt_i;
  logic                 tcdm_r_valid_i;
  logic [31:0]          tcdm_r_rdata_i;
  logic [31:0]          data_o;
  logic                 valid_o;
  logic                 ready_i;
`ifdef TCDM_RDR_CHECKSUM_EN
  logic [31:0]          checksum_o;
`endif

  tcdm_block_reader #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .len_i          (len_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .tcdm_req_o     (tcdm_req_o),
    .tcdm_add_o     (tcdm_add_o),
    .tcdm_wen_o     (tcdm_wen_o),
    .tcdm_be_o      (tcdm_be_o),
    .tcdm_wdata_o   (tcdm_wdata_o),
    .tcdm_gnt_i     (tcdm_gnt_i),
    .tcdm_r_valid_i (tcdm_r_valid_i),
    .tcdm_r_rdata_i (tcdm_r_rdata_i),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i)
`ifdef TCDM_RDR_CHECKSUM_EN
    ,
    .checksum_o     (checksum_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned due;
    logic [31:0] dat;
  } resp_t;

  resp_t       resp_q[$];
  int unsigned cyc;
  int unsigned last_due;
  int          n_tests;
  int          n_fail;
  logic        fixed_mode;
  logic [31:0] fixed_tbl [3];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Memory contents: a fixed table for the checksum case, otherwise a hash of the address.
  function automatic logic [31:0] word_for(input int k, input logic [31:0] addr);
    if (fixed_mode) return fixed_tbl[k];
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic drive_resp();
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      tcdm_r_valid_i = 1'b1;
      tcdm_r_rdata_i = resp_q[0].dat;
      void'(resp_q.pop_front());
    end else begin
      tcdm_r_valid_i = 1'b0;
      tcdm_r_rdata_i = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic run_xfer(input logic [31:0] base, input int len, input int gnt_pct,
                          input int lat_max, input int rdy_pct, input int rdy_hold,
                          input int abort_after, input bit b2b);
    logic [31:0] base_al;
    logic [31:0] exp_csum;
    logic [31:0] prev_add;
    logic [31:0] prev_dat;
    logic [31:0] wd;
    logic        prev_pend;
    logic        prev_vhold;
    logic        finished;
    logic        aborted;
    int          granted;
    int          popped;
    int          first_gc;
    int          last_gc;
    int unsigned due;
    base_al    = {base[31:2], 2'b00};
    exp_csum   = '0;
    prev_add   = '0;
    prev_dat   = '0;
    prev_pend  = 1'b0;
    prev_vhold = 1'b0;
    finished   = 1'b0;
    aborted    = 1'b0;
    granted    = 0;
    popped     = 0;
    first_gc   = 0;
    last_gc    = 0;

    start_i     = 1'b1;
    base_addr_i = base;
    len_i       = len[LEN_WIDTH-1:0];
    tcdm_gnt_i  = 1'b1;
    ready_i     = 1'b0;
    drive_resp();
    #1;
    chk("req_before_accept", {31'd0, tcdm_req_o}, 32'd0);
    step();

    for (int c = 0; c < 80 + len * 30 && !finished && !aborted; c++) begin
      tcdm_gnt_i  = ($urandom_range(99) < gnt_pct);
      ready_i     = (c >= rdy_hold) && ($urandom_range(99) < rdy_pct);
      // start pulses during a transfer must be ignored
      start_i     = ($urandom_range(7) == 0);
      base_addr_i = $urandom;
      len_i       = LEN_WIDTH'($urandom);
      drive_resp();
      #1;
      chk("busy_during", {31'd0, busy_o}, 32'd1);
      if (prev_pend) begin
        chk("req_held", {31'd0, tcdm_req_o}, 32'd1);
        chk("add_held", tcdm_add_o, prev_add);
      end
      if (prev_vhold) begin
        chk("valid_held", {31'd0, valid_o}, 32'd1);
        chk("data_held", data_o, prev_dat);
      end
      if (tcdm_req_o && tcdm_gnt_i) begin
        chk("addr", tcdm_add_o, base_al + 32'(granted) * 32'd4);
        if (granted == 0) first_gc = c;
        last_gc = c;
        granted++;
        chk("inflight_le_depth", {31'd0, (granted - popped) <= FIFO_DEPTH}, 32'd1);
        chk("no_extra_grant", {31'd0, granted <= len}, 32'd1);
        due = cyc + $urandom_range(lat_max, 1);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        resp_q.push_back('{due, word_for(granted - 1, tcdm_add_o)});
      end
      prev_pend = tcdm_req_o && !tcdm_gnt_i;
      prev_add  = tcdm_add_o;
      if (valid_o && ready_i) begin
        wd = word_for(popped, base_al + 32'(popped) * 32'd4);
        chk("data", data_o, wd);
        exp_csum ^= wd;
        popped++;
      end
      prev_vhold = valid_o && !ready_i;
      prev_dat   = data_o;
      if (done_o) begin
        chk("done_after_last_word", 32'(popped), 32'(len));
`ifdef TCDM_RDR_CHECKSUM_EN
        chk("csum_at_done", checksum_o, exp_csum);
`endif
        finished = 1'b1;
      end
      if (abort_after > 0 && granted >= abort_after) aborted = 1'b1;
      step();
    end
    start_i = 1'b0;

    if (aborted) begin
      rst_ni     = 1'b0;
      tcdm_gnt_i = 1'b1;
      ready_i    = 1'b1;
      drive_resp();
      #1;
      chk("abort_req", {31'd0, tcdm_req_o}, 32'd0);
      chk("abort_add", tcdm_add_o, 32'd0);
      chk("abort_valid", {31'd0, valid_o}, 32'd0);
      chk("abort_busy", {31'd0, busy_o}, 32'd0);
      chk("abort_done", {31'd0, done_o}, 32'd0);
      step();
      rst_ni = 1'b1;
      return;
    end

    chk("done_seen", {31'd0, finished}, 32'd1);
    chk("words_delivered", 32'(popped), 32'(len));
    chk("grants_total", 32'(granted), 32'(len));
    if (b2b) chk("b2b_span", 32'(last_gc - first_gc), 32'(len - 1));
    tcdm_gnt_i = 1'b1;
    ready_i    = 1'b1;
    drive_resp();
    #1;
    chk("done_single", {31'd0, done_o}, 32'd0);
    chk("busy_after", {31'd0, busy_o}, 32'd0);
    chk("req_after", {31'd0, tcdm_req_o}, 32'd0);
    chk("valid_after", {31'd0, valid_o}, 32'd0);
`ifdef TCDM_RDR_CHECKSUM_EN
    chk("csum_stable", checksum_o, exp_csum);
`endif
    step();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tcdm_gnt_i = $urandom_range(1);
      ready_i    = 1'b1;
      start_i    = 1'b0;
      drive_resp();
      #1;
      chk("idle_valid", {31'd0, valid_o}, 32'd0);
      chk("idle_req", {31'd0, tcdm_req_o}, 32'd0);
      chk("idle_busy", {31'd0, busy_o}, 32'd0);
      step();
    end
  endtask

  task automatic zero_len();
    start_i     = 1'b1;
    base_addr_i = $urandom;
    len_i       = '0;
    tcdm_gnt_i  = 1'b1;
    ready_i     = 1'b1;
    drive_resp();
    #1;
    chk("z_req0", {31'd0, tcdm_req_o}, 32'd0);
    step();
    start_i = 1'b0;
    #1;
    chk("z_done", {31'd0, done_o}, 32'd1);
    chk("z_busy", {31'd0, busy_o}, 32'd0);
    chk("z_req1", {31'd0, tcdm_req_o}, 32'd0);
    step();
    #1;
    chk("z_done_once", {31'd0, done_o}, 32'd0);
    chk("z_req2", {31'd0, tcdm_req_o}, 32'd0);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    cyc            = 0;
    last_due       = 0;
    fixed_mode     = 1'b0;
    fixed_tbl[0]   = 32'h0000_00FF;
    fixed_tbl[1]   = 32'h0000_FF00;
    fixed_tbl[2]   = 32'h00FF_0000;
    rst_ni         = 1'b0;
    start_i        = 1'b0;
    base_addr_i    = '0;
    len_i          = '0;
    tcdm_gnt_i     = 1'b0;
    tcdm_r_valid_i = 1'b0;
    tcdm_r_rdata_i = '0;
    ready_i        = 1'b0;

    @(negedge clk_i);
    #1;
    chk("rst_req", {31'd0, tcdm_req_o}, 32'd0);
    chk("rst_add", tcdm_add_o, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("wen", {31'd0, tcdm_wen_o}, 32'd1);
    chk("be", {28'd0, tcdm_be_o}, 32'h0000_000F);
    chk("wdata", tcdm_wdata_o, 32'd0);
`ifdef TCDM_RDR_CHECKSUM_EN
    chk("rst_csum", checksum_o, 32'd0);
`endif
    step();
    rst_ni = 1'b1;
    step();

    run_xfer(32'h1A00_0000, 8, 100, 1, 100, 0, 0, 1'b1);
    run_xfer($urandom, 16, 100, 1, 100, 20, 0, 1'b0);
    for (int i = 0; i < 3; i++) run_xfer($urandom, 16, 50, 3, 70, 0, 0, 1'b0);
    run_xfer(32'hFFFF_FFF8, 4, 60, 2, 80, 0, 0, 1'b0);
    run_xfer(32'hFFFF_FFFB, 3, 100, 1, 100, 0, 0, 1'b0);
    zero_len();
    run_xfer($urandom, 10, 100, 2, 50, 0, 3, 1'b0);
    idle_cycles(5);
    resp_q.delete();
    run_xfer($urandom, 2, 70, 3, 80, 0, 0, 1'b0);

    fixed_mode = 1'b1;
    run_xfer($urandom, 3, 80, 2, 90, 0, 0, 1'b0);
`ifdef TCDM_RDR_CHECKSUM_EN
    chk("csum_const", checksum_o, 32'h00FF_FFFF);
`endif
    fixed_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tcdm_block_reader.md
TCDM_BLOCK_READER -- requirements
Module: tcdm_block_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning response buffer depth in words (power of two, >=2).
REQ-002 SHALL have parameter LEN_WIDTH, default 16, meaning width of transfer length in words.
REQ-003 SHALL have port clk_i  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  one-cycle transfer launch; sampled only in IDLE.
REQ-006 SHALL have port base_addr_i  input  32  byte start address; bits [1:0] ignored (treated as 0).
REQ-007 SHALL have port len_i  input  LEN_WIDTH  number of 32-bit words to read.
REQ-008 SHALL have port busy_o  output  1  high from cycle after accepted start until done_o.
REQ-009 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports tcdm_req_o  output  1, tcdm_add_o  output  32, tcdm_wen_o  output  1 (constant 1 = read), tcdm_be_o  output  4 (constant 4'hF), tcdm_wdata_o  output  32 (constant 0): TCDM initiator request side.
REQ-011 SHALL have ports tcdm_gnt_i  input  1, tcdm_r_valid_i  input  1, tcdm_r_rdata_i  input  32: TCDM initiator response side.
REQ-012 SHALL have ports data_o  output  32, valid_o  output  1, ready_i  input  1: consumer stream, valid/ready.

Function
REQ-013 SHALL implement FSM IDLE -> RUN (start_i, len_i != 0) -> DRAIN (last request granted) -> IDLE (last word accepted by consumer, done_o pulsed that cycle).
REQ-014 SHALL, on start_i with len_i == 0 in IDLE, issue no request and pulse done_o the following cycle, busy_o staying low.
REQ-015 SHALL ignore start_i outside IDLE.
REQ-016 SHALL issue request k (k = 0..len-1) at address base_addr_i + 4k, modulo 2^32 (wrap from 32'hFFFF_FFFC to 0).
REQ-017 SHALL, once tcdm_req_o is asserted, hold it and tcdm_add_o stable until tcdm_gnt_i; a request is never retracted.
REQ-018 SHALL advance the address on the same edge tcdm_req_o && tcdm_gnt_i, allowing one grant per cycle back to back.
REQ-019 SHALL assert tcdm_req_o only when fifo_count + outstanding < FIFO_DEPTH, so every returning response has buffer space; outstanding = granted minus r_valid received.
REQ-020 SHALL write tcdm_r_rdata_i into the FIFO on every tcdm_r_valid_i, in order, without assuming fixed latency.
REQ-021 SHALL present FIFO head on data_o with valid_o = FIFO not empty; pop on valid_o && ready_i; simultaneous push and pop on full or empty FIFO SHALL neither drop nor duplicate data.
REQ-022 SHALL deliver exactly len_i words to the consumer in address order.

Reset
REQ-023 SHALL, during rst_ni low, drive tcdm_req_o=0, tcdm_add_o=0, valid_o=0, busy_o=0, done_o=0, FSM=IDLE, FIFO empty, outstanding=0.
REQ-024 SHALL require no synchronous init; reset mid-transfer aborts it, and responses arriving after reset release are discarded while in IDLE.

Configuration
REQ-025 SHALL, with TCDM_RDR_CHECKSUM_EN defined, add output checksum_o (32) holding the XOR of all words delivered to the consumer in the current transfer, cleared to 0 on accepted start and on reset, final value stable from done_o until next start.
REQ-026 SHALL, without TCDM_RDR_CHECKSUM_EN, have no checksum_o port and no checksum logic.

Structure
REQ-027 SHALL place FSM state typedef (IDLE/RUN/DRAIN) and constants TCDM_WEN_READ, TCDM_BE_WORD in package tcdm_block_reader_pkg.
REQ-028 SHALL implement the response buffer as sub-module tcdm_rdr_fifo (parameterised depth, 32-bit, push/pop/full/empty/count).

Verification
REQ-029 SHALL cover: base 32'h1A00_0000, len 8, gnt always 1, r_valid 1 cycle later, ready_i=1 -> 8 back-to-back grants at 1A00_0000..1A00_001C, data in order, one done_o.
REQ-030 SHALL cover: len 16, ready_i=0 throughout first 20 cycles -> at most FIFO_DEPTH grants, valid_o held, no data loss after ready_i rises.
REQ-031 SHALL cover: gnt_i random 50%, r_valid latency random 1-3 cycles -> req/add stable while ungranted, 16 words correct and ordered.
REQ-032 SHALL cover: base 32'hFFFF_FFF8, len 4 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-033 SHALL cover: len 0 -> no tcdm_req_o, done_o one cycle after start; and rst_ni low mid-transfer (len 10, after 3 grants) -> all outputs at reset values, new len 2 transfer then completes correctly.
REQ-034 SHALL cover, with TCDM_RDR_CHECKSUM_EN: words 32'h0000_00FF, 32'h0000_FF00, 32'h00FF_0000 -> checksum_o = 32'h00FF_FFFF at done_o.
